// File: rtl/data_bus_pkg.sv
// data_bus_pkg: shared constants for the data-side memory subsystem.
// Holds the address-region bases, the MMIO register offsets and the
// TCTRL bit positions used by data_bus_ctrl and mmio_timer.
package data_bus_pkg;

  localparam int unsigned DATA_W = 32;

  // Region bases: RAM when maddr[31:16] == RAM_HI, MMIO when maddr[31:8] == MMIO_BASE
  localparam logic [15:0] RAM_HI    = 16'h0000;
  localparam logic [23:0] MMIO_BASE = 24'hFFFF00;

  // MMIO register offsets (byte offsets within the MMIO page)
  localparam logic [7:0] OFF_LED   = 8'h00;
  localparam logic [7:0] OFF_SW    = 8'h04;
  localparam logic [7:0] OFF_CYCLE = 8'h08;
  localparam logic [7:0] OFF_TCMP  = 8'h0C;
  localparam logic [7:0] OFF_TCTRL = 8'h10;
  localparam logic [7:0] OFF_TCNT  = 8'h14;

  // TCTRL bit positions
  localparam int unsigned TCTRL_EN_BIT   = 0;
  localparam int unsigned TCTRL_FLAG_BIT = 1;

endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: compare timer behind the MMIO page.
// Ports:
//   clk, reset      clock and asynchronous active-low reset
//   tcmp_we         write strobe for TCMP
//   tctrl_we        write strobe for TCTRL (EN load, FLAG write-1-clear)
//   tcnt_we         write strobe for TCNT (loads the counter)
//   wdata           CPU write data shared by all three registers
//   tcmp, tcnt      register readback
//   tctrl_c         TCTRL readback assembled from EN/FLAG (other bits 0)
//   timer_irq       FLAG level
module mmio_timer
  import data_bus_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              tcmp_we,
  input  logic              tctrl_we,
  input  logic              tcnt_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] tcmp,
  output logic [DATA_W-1:0] tcnt,
  output logic [DATA_W-1:0] tctrl_c,
  output logic              timer_irq
);

  logic              en;
  logic              flag;
  logic              match;
  logic [DATA_W-1:0] tcmp_nxt;
  logic [DATA_W-1:0] tcnt_nxt;
  logic              en_nxt;
  logic              flag_nxt;

  // Next-state: CPU load of TCNT wins over counting; match-set of FLAG wins
  // over write-1-clear; match is judged on the EN value before this write.
  always_comb begin
    tcmp_nxt = tcmp;
    tcnt_nxt = tcnt;
    en_nxt   = en;
    flag_nxt = flag;
    match    = en && (tcnt == tcmp);

    if (tcmp_we) tcmp_nxt = wdata;

    if (tcnt_we)    tcnt_nxt = wdata;
    else if (match) tcnt_nxt = '0;
    else if (en)    tcnt_nxt = tcnt + DATA_W'(1);

    if (tctrl_we) en_nxt = wdata[TCTRL_EN_BIT];

    if (match)                                 flag_nxt = 1'b1;
    else if (tctrl_we && wdata[TCTRL_FLAG_BIT]) flag_nxt = 1'b0;
  end

  // Timer state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcmp <= '0;
      tcnt <= '0;
      en   <= 1'b0;
      flag <= 1'b0;
    end else begin
      tcmp <= tcmp_nxt;
      tcnt <= tcnt_nxt;
      en   <= en_nxt;
      flag <= flag_nxt;
    end
  end

  // TCTRL readback
  always_comb begin
    tctrl_c                 = '0;
    tctrl_c[TCTRL_EN_BIT]   = en;
    tctrl_c[TCTRL_FLAG_BIT] = flag;
  end

  assign timer_irq = flag;

endmodule

// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl: single-cycle data RAM plus MMIO page for the CPU M stage.
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   DM_CS/DM_R/DM_W   access select, read and write strobes
//   maddr, mwdata     byte address (bits [1:0] ignored) and write data
//   mr_data           combinational read data, 0 when not reading
//   sw_in             asynchronous switches (synchronised internally)
//   led_out           LED register
//   timer_irq         timer FLAG level
//   bus_err           registered one-cycle pulse after a bad access
module data_bus_ctrl
  import data_bus_pkg::*;
#(
  parameter int unsigned RAM_AW = 10,
  parameter int unsigned LED_W  = 16,
  parameter int unsigned SW_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              DM_CS,
  input  logic              DM_R,
  input  logic              DM_W,
  input  logic [DATA_W-1:0] maddr,
  input  logic [DATA_W-1:0] mwdata,
  output logic [DATA_W-1:0] mr_data,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out,
  output logic              timer_irq,
  output logic              bus_err
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

  logic              rd;
  logic              wr;
  logic              ram_sel;
  logic              mmio_sel;
  logic [7:0]        offset;
  logic [RAM_AW-1:0] ram_idx;

  logic [DATA_W-1:0] mem [RAM_DEPTH];
  logic [SW_W-1:0]   sw_meta;
  logic [SW_W-1:0]   sw_sync;
  logic [DATA_W-1:0] cycle;
  logic              bus_err_nxt;

  logic              tcmp_we;
  logic              tctrl_we;
  logic              tcnt_we;
  logic [DATA_W-1:0] tcmp;
  logic [DATA_W-1:0] tcnt;
  logic [DATA_W-1:0] tctrl;

  logic              unused_addr;

  // Address decode; offsets are word-aligned since maddr[1:0] is ignored
  assign rd       = DM_CS && DM_R;
  assign wr       = DM_CS && DM_W;
  assign ram_sel  = (maddr[31:16] == RAM_HI);
  assign mmio_sel = (maddr[31:8] == MMIO_BASE);
  assign offset   = {maddr[7:2], 2'b00};
  assign ram_idx  = maddr[RAM_AW+1:2];

  assign unused_addr = ^{maddr[1:0], maddr[15:RAM_AW+2]};

  // Data RAM: asynchronous read, synchronous write, no reset
  always_ff @(posedge clk) begin
    if (wr && ram_sel) mem[ram_idx] <= mwdata;
  end

  // MMIO write strobes into the timer
  assign tcmp_we  = wr && mmio_sel && (offset == OFF_TCMP);
  assign tctrl_we = wr && mmio_sel && (offset == OFF_TCTRL);
  assign tcnt_we  = wr && mmio_sel && (offset == OFF_TCNT);

  mmio_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .tcmp_we   (tcmp_we),
    .tctrl_we  (tctrl_we),
    .tcnt_we   (tcnt_we),
    .wdata     (mwdata),
    .tcmp      (tcmp),
    .tcnt      (tcnt),
    .tctrl_c   (tctrl),
    .timer_irq (timer_irq)
  );

  // Unmapped accesses and writes to read-only registers flag an error
  always_comb begin
    bus_err_nxt = 1'b0;
    if ((rd || wr) && !ram_sel && !mmio_sel) bus_err_nxt = 1'b1;
    if (wr && mmio_sel && ((offset == OFF_SW) || (offset == OFF_CYCLE))) bus_err_nxt = 1'b1;
  end

  // LED, switch synchroniser, cycle counter and error pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_out <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
      cycle   <= '0;
      bus_err <= 1'b0;
    end else begin
      if (wr && mmio_sel && (offset == OFF_LED)) led_out <= mwdata[LED_W-1:0];
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
      cycle   <= cycle + DATA_W'(1);
      bus_err <= bus_err_nxt;
    end
  end

  // Read mux; returns pre-write contents on a same-cycle read/write
  always_comb begin
    mr_data = '0;
    if (rd) begin
      if (ram_sel) begin
        mr_data = mem[ram_idx];
      end else if (mmio_sel) begin
        case (offset)
          OFF_LED:   mr_data = DATA_W'(led_out);
          OFF_SW:    mr_data = DATA_W'(sw_sync);
          OFF_CYCLE: mr_data = cycle;
          OFF_TCMP:  mr_data = tcmp;
          OFF_TCTRL: mr_data = tctrl;
          OFF_TCNT:  mr_data = tcnt;
          default:   mr_data = '0;
        endcase
      end
    end
  end

endmodule

// File: doc/data_bus_ctrl.md
# data_bus_ctrl

Data-side memory subsystem that sits directly downstream of the pipelined CPU's memory stage. It consumes the CPU's M-stage address, write data and chip-select/read/write strobes, and returns read data in the same cycle. It holds a word-addressed data RAM plus a small memory-mapped I/O region: LEDs, synchronised switches, a free-running cycle counter and a compare timer. The CPU pipeline has no stall path, so every access completes in one cycle.

## Interface
- RAM_AW, 10: RAM word-address width; the RAM holds 2^RAM_AW 32-bit words.
- LED_W, 16: LED register width.
- SW_W, 16: switch input width.

- clk  in  1  rising-edge clock shared with the CPU
- reset  in  1  asynchronous, active-low reset
- DM_CS  in  1  access select, from the CPU's M stage
- DM_R  in  1  read strobe
- DM_W  in  1  write strobe
- maddr  in  32  byte address; bits [1:0] are ignored
- mwdata  in  32  write data
- mr_data  out  32  read data, combinational
- sw_in  in  SW_W  asynchronous board switches
- led_out  out  LED_W  LED register
- timer_irq  out  1  timer flag level
- bus_err  out  1  one-cycle pulse, registered

## Operation
- **Write:** `wr = DM_CS & DM_W`. **Read:** `rd = DM_CS & DM_R`. `mr_data` is 0 whenever `rd` is 0.
- **Decode:**
  - RAM is selected when `maddr[31:16] == 0`.
  - The RAM index is `maddr[RAM_AW+1:2]`; higher bits inside the region alias.
  - MMIO is selected when `maddr[31:8] == 24'hFFFF00`, with the offset taken from `maddr[7:0]`.
  - Anything else is unmapped.
- **RAM:**
  - Reads are asynchronous, combinational from `maddr`.
  - Writes take effect at the clock edge when `wr` is high.
  - RAM contents are not reset.
- **MMIO map:** unused offsets read 0 and ignore writes.
  - 0x00 LED: RW. Low LED_W bits are used; upper bits read 0.
  - 0x04 SW: RO. Holds `sw_in` after a 2-flop synchroniser, zero-extended.
  - 0x08 CYCLE: RO, 32-bit. Increments every cycle, wraps at 0xFFFFFFFF to 0, and ignores writes.
  - 0x0C TCMP: RW, 32-bit compare value.
  - 0x10 TCTRL:
    - bit0 EN, RW.
    - bit1 FLAG, sticky. Writing 1 clears it; writing 0 has no effect.
    - Other bits read 0.
  - 0x14 TCNT: RW. A write loads the counter.
- **Timer:**
  - When EN=1 and TCNT≠TCMP, TCNT increments.
  - When EN=1 and TCNT==TCMP, TCNT becomes 0 next cycle and FLAG is set.
  - When EN=0, TCNT holds.
  - `timer_irq = FLAG`.
- **Priorities:**
  - A CPU write to TCNT beats both the increment and the match-clear.
  - A match-set of FLAG beats a same-cycle write-1-clear.
  - A write to TCTRL updates EN and the match evaluation uses the old EN.
- **Error:** `bus_err` is registered. It goes high for one cycle after any `rd` or `wr` to an unmapped address, or after a write to SW or CYCLE.
- **Strobe conflict:** if DM_R and DM_W are both high, the write happens and read data is still returned.

## Timing
- **Reset (reset=0, asynchronous):**
  - LED, TCMP, TCNT, TCTRL, CYCLE, both synchroniser stages and `bus_err` go to 0.
  - `led_out`=0 and `timer_irq`=0.
  - `mr_data` follows decode combinationally.
  - Reset release takes effect on the next rising edge.
- **Read latency:** 0 cycles; data is valid in the same cycle as the address.
- **Write:** visible to a read in the following cycle. A read of the same address in the same cycle returns the old value.
- **SW:** a `sw_in` change appears in an SW read 2–3 edges later.
- **CYCLE:** equals the number of rising edges since reset release, mod 2^32.
- **Timer period:** TCMP+1 cycles, from TCNT=0 to TCNT returning to 0. FLAG rises on the edge where TCNT wraps.
- **bus_err:** asserted the cycle after the offending access, for exactly one cycle.
- **Reset mid-operation:** a pending write is dropped and the timer stops. RAM keeps its contents.

## Structure
- Package `data_bus_pkg` holds:
  - the RAM and MMIO base constants: `RAM_HI=16'h0000`, `MMIO_BASE=24'hFFFF00`;
  - the offset constants `OFF_LED`, `OFF_SW`, `OFF_CYCLE`, `OFF_TCMP`, `OFF_TCTRL`, `OFF_TCNT`;
  - the TCTRL bit positions.
- Sub-module `mmio_timer` holds TCMP, TCNT, EN, FLAG, the match logic and the priority rules. It exposes write-enable and data inputs per register plus readback outputs.
- The top level holds decode, the RAM array, LED, the synchroniser, CYCLE, `bus_err` and the read mux.

## Test plan
- **Reset defaults:** hold reset=0, then release. Expect `led_out`=0, `timer_irq`=0, and CYCLE reads 5 at the 5th edge after release.
- **RAM write/read:**
  - Write 0xDEADBEEF to 0x00000010, then read 0x00000010 next cycle; expect 0xDEADBEEF.
  - Read with DM_R=0; expect `mr_data`=0.
  - With RAM_AW=10, 0x00001010 aliases to 0x00000010.
- **LED and SW:**
  - Write 0x0001A5A5 to 0xFFFF0000; expect `led_out`=0xA5A5.
  - Set `sw_in`=0x00FF; expect an SW read to return 0x000000FF within 3 cycles.
- **Timer:**
  - Set TCMP=3, then TCTRL=1. Expect TCNT to cycle 0,1,2,3,0 and FLAG/`timer_irq` to rise on the wrap edge.
  - Write TCTRL=0x3; expect FLAG cleared and EN kept.
- **Simultaneous events:** with TCMP=3, issue a write-1-clear to FLAG in the cycle where TCNT==3. Expect FLAG to remain 1.
- **Errors:**
  - Read 0x12340000; expect `mr_data`=0 and a one-cycle `bus_err` pulse.
  - Write to 0xFFFF0008; expect CYCLE to be unchanged and `bus_err` to pulse.
